pipe_ctrl: RTL and testbench

Sequencing and hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Owns a run/drain/halt state machine that gates program-counter fetch.
- Tracks in-flight register writers in a 3-slot scoreboard and stalls ID on RAW hazards. The datapath has no forwarding.
- Generates flush/kill controls when a taken branch resolves.
- Sits beside the datapath and drives its stage-register enables.

---
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Sequencing and RAW-hazard controller for the 5-stage MIPS pipeline.
// Gates fetch through a run/drain/halt FSM, stalls ID on scoreboard hits and squashes after taken branches.
module pipe_ctrl #(
  parameter int RWIDTH       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 d_clk,
  input  logic                 d_rst,
  input  logic                 i_start,
  input  logic                 i_halt_req,
  input  logic                 i_id_valid,
  input  logic [RWIDTH-1:0]    i_id_rs,
  input  logic [RWIDTH-1:0]    i_id_rt,
  input  logic                 i_id_use_rs,
  input  logic                 i_id_use_rt,
  input  logic                 i_id_wr_en,
  input  logic [RWIDTH-1:0]    i_id_rd,
  input  logic                 i_br_taken,
  output logic                 o_pc_ce,
  output logic                 o_if_id_en,
  output logic                 o_id_ex_bubble,
  output logic                 o_flush_if_id,
  output logic                 o_kill_ex,
  output logic                 o_busy,
  output logic                 o_halted,
  output logic [CNT_WIDTH-1:0] o_stall_cnt,
  output logic [CNT_WIDTH-1:0] o_flush_cnt
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t                r_state;
  logic [DW-1:0]         r_drainCnt;
  logic [FW-1:0]         r_flushCnt;
  logic                  r_exValid, r_memValid, r_wbValid;
  logic [RWIDTH-1:0]     r_exRd, r_memRd, r_wbRd;
  logic [CNT_WIDTH-1:0]  r_stallCnt, r_flushEvCnt;

  logic w_run, w_running, w_brTaken, w_flushActive;
  logic w_rsHit, w_rtHit, w_stall, w_issue;

  assign w_run         = (r_state == S_RUN);
  assign w_running     = w_run | (r_state == S_DRAIN);
  assign w_brTaken     = i_br_taken & w_running;
  assign w_flushActive = w_brTaken | (r_flushCnt != '0);

  // WB still counts as a hazard: the register file has no write-through.
  assign w_rsHit = (i_id_rs != '0) &&
                   ((r_exValid  && (r_exRd  == i_id_rs)) ||
                    (r_memValid && (r_memRd == i_id_rs)) ||
                    (r_wbValid  && (r_wbRd  == i_id_rs)));
  assign w_rtHit = (i_id_rt != '0) &&
                   ((r_exValid  && (r_exRd  == i_id_rt)) ||
                    (r_memValid && (r_memRd == i_id_rt)) ||
                    (r_wbValid  && (r_wbRd  == i_id_rt)));

  assign w_stall = w_run & i_id_valid &
                   ((i_id_use_rs & w_rsHit) | (i_id_use_rt & w_rtHit)) & ~w_flushActive;
  assign w_issue = w_run & i_id_valid & ~w_stall & ~w_flushActive;

  assign o_pc_ce        = w_run & ~w_stall & ~i_halt_req;
  assign o_if_id_en     = w_run & ~w_stall;
  assign o_id_ex_bubble = ~w_run | w_stall | w_flushActive;
  assign o_flush_if_id  = w_flushActive;
  assign o_kill_ex      = w_brTaken;
  assign o_busy         = w_running;
  assign o_halted       = (r_state == S_HALTED);
  assign o_stall_cnt    = r_stallCnt;
  assign o_flush_cnt    = r_flushEvCnt;

  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      r_state    <= S_IDLE;
      r_drainCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (i_start) r_state <= S_RUN;
        S_RUN: begin
          if (i_halt_req) begin
            r_state    <= S_DRAIN;
            r_drainCnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          if (r_drainCnt == '0) r_state <= S_HALTED;
          else                  r_drainCnt <= r_drainCnt - DW'(1);
        end
        S_HALTED: if (i_start) r_state <= S_RUN;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // The EX occupant during a taken branch is wrong-path, so it never reaches MEM.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      r_exValid  <= 1'b0;
      r_memValid <= 1'b0;
      r_wbValid  <= 1'b0;
      r_exRd     <= '0;
      r_memRd    <= '0;
      r_wbRd     <= '0;
      r_flushCnt <= '0;
    end else begin
      r_exValid  <= w_issue & i_id_wr_en & (i_id_rd != '0);
      r_exRd     <= i_id_rd;
      r_memValid <= r_exValid & ~w_brTaken;
      r_memRd    <= r_exRd;
      r_wbValid  <= r_memValid;
      r_wbRd     <= r_memRd;
      if (w_brTaken)               r_flushCnt <= FW'(FLUSH_CYCLES - 1);
      else if (r_flushCnt != '0)   r_flushCnt <= r_flushCnt - FW'(1);
    end
  end

  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      r_stallCnt   <= '0;
      r_flushEvCnt <= '0;
    end else begin
      if (w_stall && (r_stallCnt != '1))     r_stallCnt   <= r_stallCnt + CNT_WIDTH'(1);
      if (w_brTaken && (r_flushEvCnt != '1)) r_flushEvCnt <= r_flushEvCnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, reset/halt sequences and random traffic
// compared against a cycle-indexed behavioural model (writer history + event timestamps).
module tb_pipe_ctrl;

  localparam int RW  = 5;
  localparam int FC  = 2;
  localparam int DC  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic d_clk = 1'b0;
  logic d_rst = 1'b0;
  logic i_start, i_halt_req, i_id_valid, i_id_use_rs, i_id_use_rt, i_id_wr_en, i_br_taken;
  logic [RW-1:0] i_id_rs, i_id_rt, i_id_rd;
  logic o_pc_ce, o_if_id_en, o_id_ex_bubble, o_flush_if_id, o_kill_ex, o_busy, o_halted;
  logic [CW-1:0] o_stall_cnt, o_flush_cnt;

  pipe_ctrl #(.RWIDTH(RW), .FLUSH_CYCLES(FC), .DRAIN_CYCLES(DC), .CNT_WIDTH(CW)) dut (
    .d_clk(d_clk), .d_rst(d_rst), .i_start(i_start), .i_halt_req(i_halt_req),
    .i_id_valid(i_id_valid), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_use_rs(i_id_use_rs), .i_id_use_rt(i_id_use_rt), .i_id_wr_en(i_id_wr_en),
    .i_id_rd(i_id_rd), .i_br_taken(i_br_taken), .o_pc_ce(o_pc_ce), .o_if_id_en(o_if_id_en),
    .o_id_ex_bubble(o_id_ex_bubble), .o_flush_if_id(o_flush_if_id), .o_kill_ex(o_kill_ex),
    .o_busy(o_busy), .o_halted(o_halted), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 d_clk = ~d_clk;

  typedef struct {
    logic start, halt, valid;
    logic [RW-1:0] rs, rt;
    logic useRs, useRt, wrEn;
    logic [RW-1:0] rd;
    logic br;
  } stim_t;

  typedef struct {
    logic pcCe, ifIdEn, bubble, flushIfId, killEx, busy, halted;
  } outs_t;

  typedef struct {
    stim_t s;
    outs_t e;
  } vec_t;

  typedef struct {
    int rd;
    int cyc;
  } wr_t;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 idle, 1 run, 2 drain, 3 halted; events are cycle timestamps.
  int  mMode, mCycle, mFlushEnd, mDrainEnd, mStall, mFlush;
  wr_t mWriters[$];

  function automatic stim_t st(logic start, logic halt, logic valid, int rs, int rt,
                               logic useRs, logic useRt, logic wrEn, int rd, logic br);
    stim_t s;
    s.start = start; s.halt = halt; s.valid = valid;
    s.rs = RW'(rs); s.rt = RW'(rt);
    s.useRs = useRs; s.useRt = useRt; s.wrEn = wrEn;
    s.rd = RW'(rd); s.br = br;
    return s;
  endfunction

  function automatic outs_t ex(logic pc, logic ifid, logic bub, logic fl, logic kill,
                               logic busy, logic halted);
    outs_t e;
    e.pcCe = pc; e.ifIdEn = ifid; e.bubble = bub; e.flushIfId = fl;
    e.killEx = kill; e.busy = busy; e.halted = halted;
    return e;
  endfunction

  function automatic vec_t row(stim_t s, outs_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    return v;
  endfunction

  function automatic bit mHit(int r);
    if (r == 0) return 1'b0;
    foreach (mWriters[i])
      if (mWriters[i].rd == r && mWriters[i].cyc >= mCycle - 3 && mWriters[i].cyc <= mCycle - 1)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mMode = 0; mCycle = 0; mFlushEnd = -10; mDrainEnd = -10;
    mStall = 0; mFlush = 0;
    mWriters.delete();
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " pc_ce"}, o_pc_ce, 0);
    checkOutput({tag, " if_id_en"}, o_if_id_en, 0);
    checkOutput({tag, " bubble"}, o_id_ex_bubble, 1);
    checkOutput({tag, " flush_if_id"}, o_flush_if_id, 0);
    checkOutput({tag, " kill_ex"}, o_kill_ex, 0);
    checkOutput({tag, " busy"}, o_busy, 0);
    checkOutput({tag, " halted"}, o_halted, 0);
    checkOutput({tag, " stall_cnt"}, o_stall_cnt, 0);
    checkOutput({tag, " flush_cnt"}, o_flush_cnt, 0);
  endtask

  task automatic checkTable(input string tag, input outs_t e);
    checkOutput({tag, " pc_ce"}, o_pc_ce, e.pcCe);
    checkOutput({tag, " if_id_en"}, o_if_id_en, e.ifIdEn);
    checkOutput({tag, " bubble"}, o_id_ex_bubble, e.bubble);
    checkOutput({tag, " flush_if_id"}, o_flush_if_id, e.flushIfId);
    checkOutput({tag, " kill_ex"}, o_kill_ex, e.killEx);
    checkOutput({tag, " busy"}, o_busy, e.busy);
    checkOutput({tag, " halted"}, o_halted, e.halted);
  endtask

  // Drive one cycle, compare against the model mid-cycle, then advance the model to the next edge.
  task automatic applyStimulus(input stim_t s);
    bit brEff, flushAct, stall, issue, run, drain, hz;
    outs_t m;
    @(negedge d_clk);
    i_start = s.start; i_halt_req = s.halt; i_id_valid = s.valid;
    i_id_rs = s.rs; i_id_rt = s.rt; i_id_use_rs = s.useRs; i_id_use_rt = s.useRt;
    i_id_wr_en = s.wrEn; i_id_rd = s.rd; i_br_taken = s.br;
    #2;
    run      = (mMode == 1);
    drain    = (mMode == 2);
    brEff    = s.br && (run || drain);
    flushAct = brEff || (mCycle <= mFlushEnd);
    hz       = (s.useRs && mHit(int'(s.rs))) || (s.useRt && mHit(int'(s.rt)));
    stall    = run && s.valid && hz && !flushAct;
    issue    = run && s.valid && !stall && !flushAct;
    m = ex(run && !stall && !s.halt, run && !stall, !run || stall || flushAct,
           flushAct, brEff, run || drain, mMode == 3);
    checkOutput("model pc_ce", o_pc_ce, m.pcCe);
    checkOutput("model if_id_en", o_if_id_en, m.ifIdEn);
    checkOutput("model bubble", o_id_ex_bubble, m.bubble);
    checkOutput("model flush_if_id", o_flush_if_id, m.flushIfId);
    checkOutput("model kill_ex", o_kill_ex, m.killEx);
    checkOutput("model busy", o_busy, m.busy);
    checkOutput("model halted", o_halted, m.halted);
    checkOutput("model stall_cnt", o_stall_cnt, mStall);
    checkOutput("model flush_cnt", o_flush_cnt, mFlush);
    if (issue && s.wrEn && s.rd != '0) mWriters.push_back('{int'(s.rd), mCycle});
    if (brEff) begin
      for (int i = mWriters.size() - 1; i >= 0; i--)
        if (mWriters[i].cyc == mCycle - 1) mWriters.delete(i);
      mFlushEnd = mCycle + FC - 1;
    end
    while (mWriters.size() > 0 && mWriters[0].cyc < mCycle - 3) void'(mWriters.pop_front());
    if (stall && mStall < SAT) mStall++;
    if (brEff && mFlush < SAT) mFlush++;
    case (mMode)
      0: if (s.start) mMode = 1;
      1: if (s.halt) begin mMode = 2; mDrainEnd = mCycle + DC; end
      2: if (mCycle == mDrainEnd) mMode = 3;
      3: if (s.start) mMode = 1;
      default: mMode = 0;
    endcase
    mCycle++;
  endtask

  vec_t  tbl[$];
  stim_t rs;
  outs_t IDL, NRM, STL, FLK, FL2, HLT;

  initial begin
    IDL = ex(0, 0, 1, 0, 0, 0, 0);
    NRM = ex(1, 1, 0, 0, 0, 1, 0);
    STL = ex(0, 0, 1, 0, 0, 1, 0);
    FLK = ex(1, 1, 1, 1, 1, 1, 0);
    FL2 = ex(1, 1, 1, 1, 0, 1, 0);
    HLT = ex(0, 0, 1, 0, 0, 0, 1);

    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), IDL));
    tbl.push_back(row(st(1,0,0,0,0,0,0,0,0,0), IDL));
    tbl.push_back(row(st(0,0,1,0,0,0,0,1,5,0), NRM));
    for (int i = 0; i < 3; i++) tbl.push_back(row(st(0,0,1,5,0,1,0,0,0,0), STL));
    tbl.push_back(row(st(0,0,1,5,0,1,0,0,0,0), NRM));
    tbl.push_back(row(st(0,0,1,0,0,0,0,1,0,0), NRM));
    tbl.push_back(row(st(0,0,1,0,0,1,0,1,9,0), NRM));
    tbl.push_back(row(st(0,0,1,3,9,1,0,0,0,0), NRM));
    tbl.push_back(row(st(0,0,1,0,9,0,1,0,0,1), FLK));
    tbl.push_back(row(st(0,0,1,0,9,0,1,0,0,0), FL2));
    tbl.push_back(row(st(0,0,1,0,9,0,1,0,0,0), NRM));
    tbl.push_back(row(st(0,0,1,0,0,0,0,1,7,0), NRM));
    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,1), FLK));
    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), FL2));
    tbl.push_back(row(st(0,0,1,7,0,1,0,0,0,0), NRM));
    tbl.push_back(row(st(0,1,0,0,0,0,0,0,0,0), ex(0, 1, 0, 0, 0, 1, 0)));
    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), STL));
    tbl.push_back(row(st(1,0,0,0,0,0,0,0,0,0), STL));
    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), STL));
    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), STL));
    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), HLT));
    tbl.push_back(row(st(1,0,0,0,0,0,0,0,0,0), HLT));
    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), NRM));
    tbl.push_back(row(st(0,0,1,0,0,0,0,1,4,0), NRM));
    tbl.push_back(row(st(0,1,0,0,0,0,0,0,0,1), ex(0, 1, 1, 1, 1, 1, 0)));
    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), ex(0, 0, 1, 1, 0, 1, 0)));
    for (int i = 0; i < 3; i++) tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), STL));
    tbl.push_back(row(st(0,0,0,0,0,0,0,0,0,0), HLT));

    rs = st(0,0,0,0,0,0,0,0,0,0);
    i_start = 0; i_halt_req = 0; i_id_valid = 0; i_id_rs = '0; i_id_rt = '0;
    i_id_use_rs = 0; i_id_use_rt = 0; i_id_wr_en = 0; i_id_rd = '0; i_br_taken = 0;
    modelReset();
    repeat (2) @(negedge d_clk);
    #1 checkResetValues("por");
    @(negedge d_clk);
    d_rst = 1'b1;

    $display("[TB] directed vector table, %0d rows", tbl.size());
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].s);
      checkTable($sformatf("row%0d", i), tbl[i].e);
    end
    @(negedge d_clk);
    #1;
    checkOutput("table stall_cnt", o_stall_cnt, 3);
    checkOutput("table flush_cnt", o_flush_cnt, 3);

    $display("[TB] reset mid-RUN with a live scoreboard entry");
    applyStimulus(st(1,0,0,0,0,0,0,0,0,0));
    applyStimulus(st(0,0,1,0,0,0,0,1,6,0));
    applyStimulus(st(0,0,1,6,0,1,0,0,0,0));
    checkTable("pre-reset stall", STL);
    #1 d_rst = 1'b0;
    #1 checkResetValues("async reset");
    modelReset();
    @(negedge d_clk);
    d_rst = 1'b1;
    applyStimulus(st(0,0,1,6,0,1,0,0,0,0));
    checkTable("post-reset idle", IDL);
    applyStimulus(st(1,0,0,0,0,0,0,0,0,0));
    applyStimulus(st(0,0,1,6,0,1,0,0,0,0));
    checkTable("post-reset no stall", NRM);

    $display("[TB] randomized traffic against the model");
    for (int n = 0; n < 3000; n++) begin
      rs.start = ($urandom_range(0, 15) == 0);
      rs.halt  = ($urandom_range(0, 39) == 0);
      rs.valid = ($urandom_range(0, 3) != 0);
      rs.rs    = RW'($urandom_range(0, 3));
      rs.rt    = RW'($urandom_range(0, 3));
      rs.useRs = 1'($urandom_range(0, 1));
      rs.useRt = 1'($urandom_range(0, 1));
      rs.wrEn  = 1'($urandom_range(0, 1));
      rs.rd    = RW'($urandom_range(0, 3));
      rs.br    = ($urandom_range(0, 7) == 0);
      applyStimulus(rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
